// File: rtl/saes_cipher_core.sv
// Iterative Simplified-AES engine: one round per clock, with on-chip key expansion and a single-key cache.
// Round keys K0..KN live in rk_q and are reused while the cached K0 keeps matching in_key.
//   state    | meaning
//   S_IDLE   | waiting for a block; in_ready high
//   S_KEYEXP | derive one round key per cycle, K1..KN
//   S_ADDKEY | whitening with K0 (enc) or KN (dec)
//   S_ROUND  | one cipher round per cycle, r = 1..N
//   S_DONE   | result presented until out_ready
module saes_cipher_core #(
    parameter int NUM_ROUNDS = 2,
    parameter bit DECRYPT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_key,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEYEXP, S_ADDKEY, S_ROUND, S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(NUM_ROUNDS);

    state_t      state_q, state_d;
    logic [2:0]  rnd_q, rnd_d;
    logic [15:0] blk_q, blk_d;
    logic        mode_q, mode_d;
    logic [15:0] out_data_q, out_data_d;
    logic        key_vld_q, key_vld_d;
    logic [15:0] rk_q [8];
    logic [15:0] rk_d [8];
    logic [15:0] enc_t, dec_t;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: sbox = 4'h9;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'hD;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h8;  4'h7: sbox = 4'h5;
            4'h8: sbox = 4'h6;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h0;  4'hB: sbox = 4'h3;
            4'hC: sbox = 4'hC;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hF;  default: sbox = 4'h7;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h5;  4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hB;
            4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'h7;  4'h6: inv_sbox = 4'h8;  4'h7: inv_sbox = 4'hF;
            4'h8: inv_sbox = 4'h6;  4'h9: inv_sbox = 4'h0;  4'hA: inv_sbox = 4'h2;  4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'hC;  4'hD: inv_sbox = 4'h4;  4'hE: inv_sbox = 4'hD;  default: inv_sbox = 4'hE;
        endcase
    endfunction

    function automatic logic [15:0] sub_nib16(input logic [15:0] s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_sub_nib16(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Each byte is one column: high nibble is row 0, low nibble is row 1.
    function automatic logic [7:0] col_mul(input logic [7:0] c, input logic [3:0] d, input logic [3:0] o);
        return {gf_mul(d, c[7:4]) ^ gf_mul(o, c[3:0]), gf_mul(o, c[7:4]) ^ gf_mul(d, c[3:0])};
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {col_mul(s[15:8], 4'h1, 4'h4), col_mul(s[7:0], 4'h1, 4'h4)};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {col_mul(s[15:8], 4'h9, 4'h2), col_mul(s[7:0], 4'h9, 4'h2)};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] i);
        case (i)
            3'd1: rcon = 8'h80;  3'd2: rcon = 8'h30;  3'd3: rcon = 8'h60;
            3'd4: rcon = 8'hC0;  3'd5: rcon = 8'hB0;  default: rcon = 8'h50;
        endcase
    endfunction

    function automatic logic [15:0] key_expand(input logic [15:0] prev, input logic [2:0] i);
        logic [7:0] w_even;
        w_even = prev[15:8] ^ rcon(i) ^ {sbox(prev[3:0]), sbox(prev[7:4])};
        return {w_even, w_even ^ prev[7:0]};
    endfunction

    always_comb begin
        enc_t = shift_rows(sub_nib16(blk_q));
        if (rnd_q != LAST) enc_t = mix_col(enc_t);
        enc_t = enc_t ^ rk_q[rnd_q];
    end

    if (DECRYPT_EN) begin : g_dec
        always_comb begin
            dec_t = inv_sub_nib16(shift_rows(blk_q)) ^ rk_q[LAST - rnd_q];
            if (rnd_q != LAST) dec_t = inv_mix_col(dec_t);
        end
    end else begin : g_no_dec
        assign dec_t = '0;
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        blk_d      = blk_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        key_vld_d  = key_vld_q;
        rk_d       = rk_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    blk_d  = in_data;
                    mode_d = in_mode & DECRYPT_EN;
                    if (key_vld_q && (in_key == rk_q[0])) begin
                        state_d = S_ADDKEY;
                    end else begin
                        rk_d[0]   = in_key;
                        key_vld_d = 1'b0;
                        rnd_d     = 3'd1;
                        state_d   = S_KEYEXP;
                    end
                end
            end
            S_KEYEXP: begin
                rk_d[rnd_q] = key_expand(rk_q[rnd_q - 3'd1], rnd_q);
                if (rnd_q == LAST) begin
                    key_vld_d = 1'b1;
                    state_d   = S_ADDKEY;
                end else begin
                    rnd_d = rnd_q + 3'd1;
                end
            end
            S_ADDKEY: begin
                blk_d   = blk_q ^ (mode_q ? rk_q[LAST] : rk_q[0]);
                rnd_d   = 3'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                blk_d = (DECRYPT_EN && mode_q) ? dec_t : enc_t;
                if (rnd_q == LAST) begin
                    out_data_d = blk_d;
                    state_d    = S_DONE;
                end else begin
                    rnd_d = rnd_q + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rnd_q      <= 3'd1;
            blk_q      <= '0;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            key_vld_q  <= 1'b0;
            for (int i = 0; i < 8; i++) rk_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            blk_q      <= blk_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            key_vld_q  <= key_vld_d;
            rk_q       <= rk_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;

endmodule
